imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Byte-stream program loader: the write-side counterpart of the single-cycle instruction memory. It receives a framed program image one byte at a time over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into instruction memory at byte addresses 0, 4, 8, …. It holds the CPU in reset until a load completes with a correct checksum.

Parameters:
DEPTH, 64, instruction memory capacity in 32-bit words; maximum accepted word count
ADDR_W, 32, width of mem_addr (byte address)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load (honoured in IDLE, DONE, ERROR only)
rx_data  input  8  incoming stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  ADDR_W  byte address of word being written (4*word_index)
mem_wdata  output  32  assembled instruction word
cpu_hold  output  1  keep CPU in reset while 1
load_done  output  1  sticky: last load succeeded
load_error  output  1  sticky: last load failed (length or checksum)
words_loaded  output  16  number of words written in current/last load

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word LSB first), then 1 checksum byte = 8-bit sum mod 256 of all data bytes (length bytes excluded).
- Byte transfer occurs on a rising edge where rx_valid && rx_ready.
- Reset values:
  - state IDLE
  - rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0
  - cpu_hold 1, load_done 0, load_error 0, words_loaded 0
  - internal checksum, byte counter and word counter cleared
- States:
  - IDLE: rx_ready 0. start -> LEN_LO; clear flags, words_loaded, checksum; cpu_hold stays 1.
  - LEN_LO: rx_ready 1. Accepted byte -> length[7:0]; -> LEN_HI.
  - LEN_HI: rx_ready 1. Accepted byte -> length[15:8]. Then:
    - length > DEPTH -> ERROR, with no writes.
    - length == 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: rx_ready 1. Accepted bytes are shifted into word byte lanes 0..3 and added into the checksum.
    - The cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle, mem_addr=4*words_loaded, mem_wdata={b3,b2,b1,b0}; words_loaded increments in the same cycle.
    - rx_ready stays 1 throughout, so the next word's byte may be accepted in the write cycle.
    - After word N is written -> CHECK.
  - CHECK: rx_ready 1. Accepted byte equal to checksum -> DONE; otherwise -> ERROR.
  - DONE: rx_ready 0, load_done 1, cpu_hold 0. start -> LEN_LO; clears flags and reasserts cpu_hold the next cycle.
  - ERROR: rx_ready 0, load_error 1, cpu_hold 1. start -> LEN_LO, same as from DONE.
- start pulses while in LEN_LO, LEN_HI, DATA or CHECK are ignored.
- Words already written are not rolled back on ERROR; cpu_hold keeps the CPU from running them.
- rx_valid gaps of any length are tolerated in every receiving state; there is no timeout.
- The last data word's mem_we fires in the same cycle as the transition to CHECK. A checksum byte accepted in that cycle is valid.
- Reset asserted mid-load: next cycle all outputs return to reset values and mem_we is 0. Partially written memory contents are left untouched.
- words_loaded saturates at DEPTH; it cannot exceed it because of the length check.

Test Plan:
1. start; stream 02 00 | 13 00 00 00 | 63 86 94 00 | 90 -> mem_we at addr 0 data 0x00000013, then addr 4 data 0x00948663; load_done=1, cpu_hold=0, words_loaded=2, load_error=0.
2. Same stream with checksum 0x91 -> both writes occur; load_error=1, load_done=0, cpu_hold=1.
3. start; stream 41 00 (N=65, DEPTH=64) -> ERROR right after LEN_HI; no mem_we; rx_ready=0; further bytes are not accepted.
4. start; stream 00 00 00 -> DONE with zero writes, words_loaded=0, cpu_hold=0.
5. Test 1 stream with rx_valid low every other cycle and random stalls -> identical writes and flags; mem_we still exactly one cycle per word.
6. Test 1 stream with reset pulsed after 6 data bytes -> IDLE, rx_ready=0, cpu_hold=1, flags 0, no further writes. A following start with a full test 1 stream -> load_done=1. A start pulse sent in DATA is ignored.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed little-endian image, writes 32-bit words
// into instruction memory and releases the CPU only after a load with a correct checksum.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t              r_state;
  logic [15:0]         r_len;
  logic [7:0]          r_csum;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_word;
  logic                r_rx_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic                r_load_error;
  logic [15:0]         r_words_loaded;

  logic                w_accept;
  logic [15:0]         w_len_full;
  logic [15:0]         w_depth;
  logic [15:0]         w_words_next;

  assign w_accept     = rx_valid && r_rx_ready;
  assign w_len_full   = {rx_data, r_len[7:0]};
  assign w_depth      = 16'(DEPTH);
  assign w_words_next = r_words_loaded + 16'd1;

  assign rx_ready     = r_rx_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_error   = r_load_error;
  assign words_loaded = r_words_loaded;

  // Loader FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_len          <= 16'd0;
      r_csum         <= 8'd0;
      r_byte_cnt     <= 2'd0;
      r_word         <= 24'd0;
      r_rx_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= {ADDR_W{1'b0}};
      r_mem_wdata    <= 32'd0;
      r_cpu_hold     <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_words_loaded <= 16'd0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state        <= S_LEN_LO;
            r_rx_ready     <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
            r_cpu_hold     <= 1'b1;
            r_words_loaded <= 16'd0;
            r_csum         <= 8'd0;
            r_byte_cnt     <= 2'd0;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= rx_data;
            if (w_len_full > w_depth) begin
              r_state      <= S_ERROR;
              r_rx_ready   <= 1'b0;
              r_load_error <= 1'b1;
            end else if (w_len_full == 16'd0) begin
              r_state <= S_CHECK;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum + rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                // Fourth byte completes the word; the write lands next cycle.
                r_mem_we       <= 1'b1;
                r_mem_addr     <= ADDR_W'({r_words_loaded, 2'b00});
                r_mem_wdata    <= {rx_data, r_word};
                r_words_loaded <= w_words_next;
                if (w_words_next == r_len) begin
                  r_state <= S_CHECK;
                end
              end
            endcase
          end
        end
        S_CHECK: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (rx_data == r_csum) begin
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as data bytes are driven
// and checked whenever the loader strobes mem_we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];

  imem_loader #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_we", {mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check_val("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int tries = 0;
    if (stall) begin
      rx_valid = 1'b0;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) check_val("rx_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Send stream[first..last-1], queueing each word's expected write at its 4th data byte.
  task automatic send_stream(input int first, input int last, input bit stall, input int start_at);
    int n;
    n = int'({stream[1], stream[0]});
    for (int i = first; i < last; i++) begin
      if (i == start_at) pulse_start();
      if (n <= 64 && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
        exp_q.push_back({32'((i - 5) / 4 * 4),
                         stream[i], stream[i-1], stream[i-2], stream[i-3]});
      end
      send_byte(stream[i], stall);
    end
  endtask

  task automatic build_test1(input logic [7:0] csum);
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h63, 8'h86, 8'h94, 8'h00, csum};
  endtask

  task automatic check_flags(input string tag, input logic done, input logic err,
                             input logic hold, input logic [15:0] words);
    repeat (2) @(negedge clk);
    check_val({tag, "_done"},  64'(load_done),    64'(done));
    check_val({tag, "_err"},   64'(load_error),   64'(err));
    check_val({tag, "_hold"},  64'(cpu_hold),     64'(hold));
    check_val({tag, "_words"}, 64'(words_loaded), 64'(words));
    check_val({tag, "_ready"}, 64'(rx_ready),     64'd0);
    check_val({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] good_sum;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(rx_ready), 64'd0);
    check_val("rst_we",    64'(mem_we),   64'd0);
    check_val("rst_addr",  64'(mem_addr), 64'd0);
    check_val("rst_wdata", 64'(mem_wdata), 64'd0);
    check_val("rst_hold",  64'(cpu_hold), 64'd1);
    check_val("rst_flags", {62'd0, load_done, load_error}, 64'd0);
    check_val("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: two-word image, good checksum
    good_sum = 8'h13 + 8'h63 + 8'h86 + 8'h94;
    build_test1(good_sum);
    pulse_start();
    check_val("t1_ready_after_start", 64'(rx_ready), 64'd1);
    send_stream(0, 11, 1'b0, -1);
    check_flags("t1", 1'b1, 1'b0, 1'b0, 16'd2);

    // Test 2: same image, bad checksum; start from DONE reasserts hold
    build_test1(good_sum + 8'd1);
    pulse_start();
    check_val("t2_hold_on_start", 64'(cpu_hold), 64'd1);
    check_val("t2_done_cleared",  64'(load_done), 64'd0);
    send_stream(0, 11, 1'b0, -1);
    check_flags("t2", 1'b0, 1'b1, 1'b1, 16'd2);

    // Test 3: length above capacity
    stream = '{8'h41, 8'h00};
    pulse_start();
    send_stream(0, 2, 1'b0, -1);
    check_val("t3_ready_after_len", 64'(rx_ready), 64'd0);
    rx_valid = 1'b1; rx_data = 8'h55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("t3_no_accept", 64'(rx_ready), 64'd0);
    end
    rx_valid = 1'b0;
    check_flags("t3", 1'b0, 1'b1, 1'b1, 16'd0);

    // Test 4: empty image
    stream = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_stream(0, 3, 1'b0, -1);
    check_flags("t4", 1'b1, 1'b0, 1'b0, 16'd0);

    // Test 5: test 1 stream with random valid gaps
    build_test1(good_sum);
    pulse_start();
    send_stream(0, 11, 1'b1, -1);
    check_flags("t5", 1'b1, 1'b0, 1'b0, 16'd2);

    // Test 6: reset after six data bytes, then a full reload with a stray start in DATA
    build_test1(good_sum);
    pulse_start();
    send_stream(0, 8, 1'b0, -1);
    reset = 1'b1;
    @(negedge clk);
    check_val("t6_rst_ready", 64'(rx_ready), 64'd0);
    check_val("t6_rst_hold",  64'(cpu_hold), 64'd1);
    check_val("t6_rst_flags", {62'd0, load_done, load_error}, 64'd0);
    check_val("t6_rst_words", 64'(words_loaded), 64'd0);
    check_val("t6_rst_we",    64'(mem_we), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("t6_idle_ready", 64'(rx_ready), 64'd0);
    pulse_start();
    send_stream(0, 11, 1'b0, 4);
    check_flags("t6", 1'b1, 1'b0, 1'b0, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
